// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: sequences the CPU clock-enable pulse from the free-running
// divider bus. Supports fast-run, slow-run, single-step and halt modes.
// Also debounces the step button and counts issued CPU cycles.
// Single clock domain; the CPU is gated by cpu_ce, never by a derived clock.
module cpu_clk_ctrl #(
  parameter int FAST_TAP  = 2,
  parameter int SLOW_TAP  = 24,
  parameter int DB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clkdiv,
  input  logic        SW2,
  input  logic        step_en,
  input  logic        halt,
  input  logic        step_btn,
  input  logic        cnt_clr,
  output logic        cpu_ce,
  output logic [1:0]  mode,
  output logic [10:0] cycle_cnt
);

  typedef enum logic [1:0] {
    HALT = 2'b00,
    FAST = 2'b01,
    SLOW = 2'b10,
    STEP = 2'b11
  } mode_t;

  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  mode_t          mode_q;
  mode_t          req_mode;
  logic           tap_q;
  logic           tap_cur;
  logic           tap_next;
  logic           tick;

  logic           s1;
  logic           s2;
  logic           stable;
  logic           stable_q;
  logic           step_req;
  logic [DBW-1:0] db_cnt;

  // Halt and step share the fast time base so a return to FAST is seamless.
  function automatic logic [4:0] tap_of(input mode_t m);
    return (m == SLOW) ? 5'(SLOW_TAP) : 5'(FAST_TAP);
  endfunction

  // Requested mode, strict priority: halt > step > slow > fast.
  always_comb begin
    // NOTE: a default first keeps every path assigned, so no latch is inferred.
    req_mode = FAST;
    if (halt)         req_mode = HALT;
    else if (step_en) req_mode = STEP;
    else if (SW2)     req_mode = SLOW;
  end

  // Tap history is reloaded from the incoming mode's tap, so a switch never ticks.
  assign tap_cur  = clkdiv[tap_of(mode_q)];
  assign tap_next = clkdiv[tap_of(req_mode)];
  assign tick     = tap_cur & ~tap_q;

  // Button synchroniser, debounce counter and registered rising-edge request.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      step_req <= 1'b0;
      db_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1 <= step_btn;
      s2 <= s1;
      if (s2 != stable) begin
        if (db_cnt == DB_LAST) begin
          stable <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
      stable_q <= stable;
      step_req <= stable & ~stable_q;
    end
  end

  // Mode register, tap history and the registered clock-enable pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= HALT;
      tap_q  <= 1'b0;
      cpu_ce <= 1'b0;
    end else begin
      mode_q <= req_mode;
      tap_q  <= tap_next;
      if (req_mode != mode_q) begin
        cpu_ce <= 1'b0;
      end else begin
        case (mode_q)
          FAST, SLOW: cpu_ce <= tick;
          STEP:       cpu_ce <= step_req;
          default:    cpu_ce <= 1'b0;
        endcase
      end
    end
  end

  // Issued-cycle counter; clear wins over a coincident pulse, wraps at 2048.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) cycle_cnt <= '0;
    else if (cpu_ce)    cycle_cnt <= cycle_cnt + 1'b1;
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed stimulus with a pulse scoreboard. Expected cpu_ce
// pulses are queued as the clkdiv value sampled on the edge that raises cpu_ce.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] clkdiv = 32'd0;
  logic        SW2;
  logic        step_en;
  logic        halt;
  logic        step_btn;
  logic        cnt_clr;
  logic        cpu_ce;
  logic [1:0]  mode;
  logic [10:0] cycle_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  cpu_clk_ctrl #(
    .FAST_TAP (2),
    .SLOW_TAP (4),
    .DB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clkdiv   (clkdiv),
    .SW2      (SW2),
    .step_en  (step_en),
    .halt     (halt),
    .step_btn (step_btn),
    .cnt_clr  (cnt_clr),
    .cpu_ce   (cpu_ce),
    .mode     (mode),
    .cycle_cnt(cycle_cnt)
  );

  // Clock: posedge k (k = 1, 2, ...) samples clkdiv = k-1.
  initial forever #5 clk = ~clk;

  // Divider bus advances mid-cycle, one count per clk.
  initial forever begin
    @(negedge clk);
    clkdiv = clkdiv + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (clkdiv=%0d)", name, act, exp, clkdiv);
  endtask

  // Returns after the negedge where clkdiv becomes v: outputs reflect edge v-1,
  // and inputs driven now are sampled on the edge that sees clkdiv = v.
  task automatic tick_to(input int unsigned v);
    while (clkdiv < v) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Monitor: every cpu_ce pulse must match the head of the expected queue.
  initial forever begin
    @(posedge clk);
    #1;
    if (cpu_ce === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: cpu_ce=1 at stamp %0d, none expected", clkdiv);
      end else begin
        check("pulse_stamp", clkdiv, exp_q.pop_front());
      end
    end
  end

  // Watchdog: the run is bounded even if the stimulus stalls.
  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit, %0d checks made", n_checks);
    $fatal(1, "timeout");
  end

  // Directed stimulus with hand-computed pulse stamps and counter values.
  initial begin
    rst = 1'b1; halt = 1'b0; step_en = 1'b0; SW2 = 1'b0;
    step_btn = 1'b0; cnt_clr = 1'b0;

    // Reset state.
    tick_to(4);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_cnt", 32'(cycle_cnt), 32'd0);

    // FAST: switch at 4 is silent, then a pulse every 8 on the bit-2 rise.
    for (int i = 0; i < 10; i++) exp_q.push_back(32'd12 + 32'(8 * i));
    rst = 1'b0;
    tick_to(86);
    check("fast_mode", 32'(mode), 32'd1);
    check("fast_cnt10", 32'(cycle_cnt), 32'd10);

    // SLOW: switch lands on a due FAST tick, which must be suppressed.
    tick_to(92);
    SW2 = 1'b1;
    exp_q.push_back(32'd112);
    exp_q.push_back(32'd144);
    exp_q.push_back(32'd176);
    tick_to(94);
    check("slow_mode", 32'(mode), 32'd2);
    check("switch_no_pulse_cnt", 32'(cycle_cnt), 32'd10);

    // STEP: bouncy press, accepted press pulses at 194 + DB + 3.
    tick_to(180);
    step_en = 1'b1;
    tick_to(182);
    check("step_mode", 32'(mode), 32'd3);
    check("slow_cnt13", 32'(cycle_cnt), 32'd13);
    exp_q.push_back(32'd201);
    tick_to(190); step_btn = 1'b1;
    tick_to(191); step_btn = 1'b0;
    tick_to(192); step_btn = 1'b1;
    tick_to(193); step_btn = 1'b0;
    tick_to(194); step_btn = 1'b1;
    // Bouncy release produces no pulse.
    tick_to(214); step_btn = 1'b0;
    tick_to(215); step_btn = 1'b1;
    tick_to(216); step_btn = 1'b0;
    // SW2 is ignored while step_en is high.
    tick_to(220); SW2 = 1'b0;
    tick_to(222);
    check("step_ignores_sw2", 32'(mode), 32'd3);

    // Back to FAST, then halt on the cycle a tick is due.
    tick_to(240);
    check("step_cnt14", 32'(cycle_cnt), 32'd14);
    step_en = 1'b0;
    exp_q.push_back(32'd244);
    exp_q.push_back(32'd252);
    tick_to(260); halt = 1'b1;
    tick_to(261);
    check("halt_mode", 32'(mode), 32'd0);
    check("halt_ce", 32'(cpu_ce), 32'd0);
    tick_to(262);
    check("halt_cnt16", 32'(cycle_cnt), 32'd16);
    // Press while halted is discarded.
    tick_to(270); step_btn = 1'b1;
    tick_to(290); step_btn = 1'b0;
    tick_to(300);
    check("halt_press_cnt", 32'(cycle_cnt), 32'd16);
    check("halt_still", 32'(mode), 32'd0);

    // Counter wrap: clear, then 2047 pulses, then one more.
    tick_to(304);
    halt = 1'b0; cnt_clr = 1'b1;
    for (int i = 0; i < 2051; i++) exp_q.push_back(32'd308 + 32'(8 * i));
    tick_to(305);
    cnt_clr = 1'b0;
    check("clr_cnt", 32'(cycle_cnt), 32'd0);
    tick_to(16680);
    check("cnt_2047", 32'(cycle_cnt), 32'd2047);
    tick_to(16687);
    check("cnt_wrap", 32'(cycle_cnt), 32'd0);
    // Clear coincident with the pulse at 16700.
    tick_to(16701); cnt_clr = 1'b1;
    tick_to(16702);
    check("clr_beats_pulse", 32'(cycle_cnt), 32'd0);
    cnt_clr = 1'b0;

    // Mid-run reset with the debounce partly advanced.
    tick_to(16706); step_btn = 1'b1;
    tick_to(16710); rst = 1'b1;
    tick_to(16711);
    check("mid_rst_mode", 32'(mode), 32'd0);
    check("mid_rst_ce", 32'(cpu_ce), 32'd0);
    check("mid_rst_cnt", 32'(cycle_cnt), 32'd0);
    rst = 1'b0; step_en = 1'b1;
    exp_q.push_back(32'd16718);
    tick_to(16720);
    check("post_rst_cnt", 32'(cycle_cnt), 32'd1);
    check("post_rst_mode", 32'(mode), 32'd3);
    tick_to(16722); step_btn = 1'b0;

    tick_to(16740);
    check("pending_pulses", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
